// File: rtl/dtcm_pkg.sv
// Shared types and helpers for the data-TCM controller: FSM states, port ids, byte merge.
package dtcm_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_A = 1'b0;
    localparam port_id_t PORT_B = 1'b1;

    // Merge helper works on the widest supported word; callers zero-extend and truncate.
    localparam int MAX_DW = 64;
    localparam int MAX_BW = MAX_DW / 8;

    function automatic logic [MAX_DW-1:0] merge_bytes(input logic [MAX_DW-1:0] old_word,
                                                      input logic [MAX_DW-1:0] new_word,
                                                      input logic [MAX_BW-1:0] be);
        logic [MAX_DW-1:0] result;
        for (int i = 0; i < MAX_BW; i++) begin
            result[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/dtcm_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the port not granted last wins a tie.
module rr_arb2
    import dtcm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    port_id_t last_grant_q;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == PORT_B) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_B;
        end else if (accept) begin
            last_grant_q <= grant[PORT_B] ? PORT_B : PORT_A;
        end
    end

endmodule

// File: rtl/dtcm_ctrl.sv
// Data-TCM controller: arbitrates LSU (A) and debug/DMA (B) ports onto one TCM,
// turning partial byte-enable stores into a read-modify-write.
module dtcm_ctrl
    import dtcm_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_req,
    input  logic            a_we,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_wdata,
    input  logic [DW/8-1:0] a_be,
    output logic            a_ready,
    output logic            a_rvalid,
    output logic [DW-1:0]   a_rdata,
    input  logic            b_req,
    input  logic            b_we,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_wdata,
    input  logic [DW/8-1:0] b_be,
    output logic            b_ready,
    output logic            b_rvalid,
    output logic [DW-1:0]   b_rdata,
    output logic [AW-1:0]   m_waddr,
    output logic [DW-1:0]   m_wdata,
    output logic            m_wen,
    output logic [AW-1:0]   m_raddr,
    output logic            m_ren,
    input  logic [DW-1:0]   m_rdata
);

    localparam int BW = DW / 8;

    state_t          state_q;
    logic [AW-1:0]   rmw_addr_q;
    logic [DW-1:0]   rmw_data_q;
    port_id_t        rmw_owner_q;

    logic [1:0]      req;
    logic [1:0]      grant;
    logic            accept;
    port_id_t        sel;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [BW-1:0]   sel_be;
    logic            sel_full;
    logic            sel_partial;
    logic [DW-1:0]   merged;

    // Nothing is granted while the RMW write-back owns the TCM.
    assign req = (state_q == IDLE) ? {b_req, a_req} : 2'b00;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    assign accept  = |grant;
    assign a_ready = grant[PORT_A];
    assign b_ready = grant[PORT_B];
    assign sel     = grant[PORT_B] ? PORT_B : PORT_A;

    always_comb begin
        sel_we    = a_we;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        sel_be    = a_be;
        if (sel == PORT_B) begin
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
            sel_be    = b_be;
        end
    end

    assign sel_full    = (sel_be == {BW{1'b1}});
    assign sel_partial = (sel_be != '0) && !sel_full;
    assign merged      = DW'(merge_bytes(MAX_DW'(m_rdata), MAX_DW'(sel_wdata), MAX_BW'(sel_be)));

    // Read port only enabled for reads and the old-word fetch of a partial write.
    assign m_ren   = accept && (!sel_we || sel_partial);
    assign m_raddr = sel_addr;
    assign m_wen   = (state_q == RMW_WR) || (accept && sel_we && sel_full);
    assign m_waddr = (state_q == RMW_WR) ? rmw_addr_q : sel_addr;
    assign m_wdata = (state_q == RMW_WR) ? rmw_data_q : sel_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rmw_addr_q  <= '0;
            rmw_data_q  <= '0;
            rmw_owner_q <= PORT_A;
            a_rvalid    <= 1'b0;
            a_rdata     <= '0;
            b_rvalid    <= 1'b0;
            b_rdata     <= '0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (sel_we && sel_partial) begin
                            rmw_addr_q  <= sel_addr;
                            rmw_data_q  <= merged;
                            rmw_owner_q <= sel;
                            state_q     <= RMW_WR;
                        end else if (sel == PORT_A) begin
                            a_rvalid <= 1'b1;
                            a_rdata  <= sel_we ? '0 : m_rdata;
                        end else begin
                            b_rvalid <= 1'b1;
                            b_rdata  <= sel_we ? '0 : m_rdata;
                        end
                    end
                end
                RMW_WR: begin
                    state_q <= IDLE;
                    if (rmw_owner_q == PORT_A) begin
                        a_rvalid <= 1'b1;
                        a_rdata  <= '0;
                    end else begin
                        b_rvalid <= 1'b1;
                        b_rdata  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Directed bench for dtcm_ctrl with a behavioural TCM (combinational read, Z when idle).
module tb_dtcm_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic [BW-1:0] a_be, b_be;
    logic          a_ready, a_rvalid, b_ready, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] m_waddr, m_raddr;
    logic [DW-1:0] m_wdata;
    logic          m_wen, m_ren;
    wire  [DW-1:0] m_rdata;

    logic [DW-1:0] mem [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (m_wen) mem[m_waddr] <= m_wdata;
    assign m_rdata = m_ren ? mem[m_raddr] : 32'hzzzz_zzzz;

    dtcm_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_be     (a_be),
        .a_ready  (a_ready),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_be     (b_be),
        .b_ready  (b_ready),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .m_waddr  (m_waddr),
        .m_wdata  (m_wdata),
        .m_wen    (m_wen),
        .m_raddr  (m_raddr),
        .m_ren    (m_ren),
        .m_rdata  (m_rdata)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [BW-1:0] be);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [BW-1:0] be);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
    endtask

    // Full-word write through port A, response not inspected.
    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        drive_a(1'b1, 1'b1, addr, data, 4'hF);
        tick();
        drive_a(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic read_a(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        drive_a(1'b1, 1'b0, addr, '0, '0);
        #1;
        check({tag, " ready"}, 32'(a_ready), 32'd1);
        check({tag, " m_ren"}, 32'(m_ren), 32'd1);
        tick();
        drive_a(1'b0, 1'b0, '0, '0, '0);
        check({tag, " rvalid"}, 32'(a_rvalid), 32'd1);
        check({tag, " rdata"}, a_rdata, exp);
    endtask

    initial begin
        drive_a(1'b0, 1'b0, '0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0, '0);
        repeat (2) tick();
        check("rst a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst b_rvalid", 32'(b_rvalid), 32'd0);
        check("rst a_rdata", a_rdata, 32'd0);
        check("rst b_rdata", b_rdata, 32'd0);
        check("rst m_wen", 32'(m_wen), 32'd0);
        check("rst m_ren", 32'(m_ren), 32'd0);
        rst_n = 1'b1;
        tick();

        preload(4'd2, 32'h1234_5678);

        // Full write then read back on port A
        drive_a(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF);
        #1;
        check("t1 wr ready", 32'(a_ready), 32'd1);
        check("t1 wr m_wen", 32'(m_wen), 32'd1);
        tick();
        drive_a(1'b0, 1'b0, '0, '0, '0);
        check("t1 wr rvalid", 32'(a_rvalid), 32'd1);
        check("t1 wr rdata", a_rdata, 32'd0);
        read_a("t1 rd", 4'd3, 32'hDEAD_BEEF);
        check("t1 b_rvalid", 32'(b_rvalid), 32'd0);

        // BE==0 write is a no-op ack
        drive_a(1'b1, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'h0);
        #1;
        check("t4 ready", 32'(a_ready), 32'd1);
        check("t4 m_wen", 32'(m_wen), 32'd0);
        check("t4 m_ren", 32'(m_ren), 32'd0);
        tick();
        drive_a(1'b0, 1'b0, '0, '0, '0);
        check("t4 rvalid", 32'(a_rvalid), 32'd1);
        check("t4 rdata", a_rdata, 32'd0);
        check("t4 m_wen after", 32'(m_wen), 32'd0);
        read_a("t4 rd", 4'd2, 32'h1234_5678);

        // Partial write from B: RMW with latency 2, A blocked during RMW_WR
        drive_b(1'b1, 1'b1, 4'd5, 32'h1122_3344, 4'hF);
        tick();
        drive_b(1'b1, 1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101);
        #1;
        check("t3 b_ready", 32'(b_ready), 32'd1);
        check("t3 m_ren", 32'(m_ren), 32'd1);
        check("t3 m_wen accept", 32'(m_wen), 32'd0);
        tick();
        drive_b(1'b0, 1'b0, '0, '0, '0);
        drive_a(1'b1, 1'b0, 4'd5, '0, '0);
        #1;
        check("t3 a_ready rmw", 32'(a_ready), 32'd0);
        check("t3 m_wen rmw", 32'(m_wen), 32'd1);
        check("t3 m_waddr", 32'(m_waddr), 32'd5);
        check("t3 m_wdata", m_wdata, 32'h11BB_33DD);
        check("t3 b_rvalid early", 32'(b_rvalid), 32'd0);
        tick();
        check("t3 b_rvalid", 32'(b_rvalid), 32'd1);
        check("t3 b_rdata", b_rdata, 32'd0);
        check("t3 a_rvalid", 32'(a_rvalid), 32'd0);
        check("t3 a_ready idle", 32'(a_ready), 32'd1);
        tick();
        drive_a(1'b0, 1'b0, '0, '0, '0);
        check("t3 rd rvalid", 32'(a_rvalid), 32'd1);
        check("t3 rd rdata", a_rdata, 32'h11BB_33DD);

        // Reset during RMW_WR drops the write-back
        drive_b(1'b1, 1'b1, 4'd5, 32'h0000_0000, 4'b1000);
        tick();
        drive_b(1'b0, 1'b0, '0, '0, '0);
        check("t5 m_wen pre", 32'(m_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5 m_wen rst", 32'(m_wen), 32'd0);
        check("t5 b_rvalid rst", 32'(b_rvalid), 32'd0);
        tick();
        check("t5 b_rvalid", 32'(b_rvalid), 32'd0);
        check("t5 m_wen", 32'(m_wen), 32'd0);
        rst_n = 1'b1;
        read_a("t5 rd", 4'd5, 32'h11BB_33DD);

        // Both ports requesting from reset alternate A, B, A, B
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive_a(1'b1, 1'b0, 4'd3, '0, '0);
        drive_b(1'b1, 1'b0, 4'd2, '0, '0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("t2 a_ready %0d", i), 32'(a_ready), 32'(i % 2 == 0));
            check($sformatf("t2 b_ready %0d", i), 32'(b_ready), 32'(i % 2 == 1));
            tick();
            check($sformatf("t2 a_rvalid %0d", i), 32'(a_rvalid), 32'(i % 2 == 0));
            check($sformatf("t2 b_rvalid %0d", i), 32'(b_rvalid), 32'(i % 2 == 1));
            if (i % 2 == 0) check($sformatf("t2 a_rdata %0d", i), a_rdata, 32'hDEAD_BEEF);
            else            check($sformatf("t2 b_rdata %0d", i), b_rdata, 32'h1234_5678);
        end
        drive_a(1'b0, 1'b0, '0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0, '0);
        tick();

        // A read issued during B's RMW_WR sees the merged word
        preload(4'd7, 32'hCAFE_F00D);
        drive_b(1'b1, 1'b1, 4'd7, 32'h0000_0099, 4'b0001);
        #1;
        check("t6 b_ready", 32'(b_ready), 32'd1);
        tick();
        drive_b(1'b0, 1'b0, '0, '0, '0);
        drive_a(1'b1, 1'b0, 4'd7, '0, '0);
        #1;
        check("t6 a_ready rmw", 32'(a_ready), 32'd0);
        tick();
        check("t6 b_rvalid", 32'(b_rvalid), 32'd1);
        check("t6 a_ready idle", 32'(a_ready), 32'd1);
        check("t6 m_raddr", 32'(m_raddr), 32'd7);
        tick();
        drive_a(1'b0, 1'b0, '0, '0, '0);
        check("t6 a_rvalid", 32'(a_rvalid), 32'd1);
        check("t6 a_rdata", a_rdata, 32'hCAFE_F099);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
